// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the pipeline stages.
// Holds the fetch bundle, fetch FSM states and exception codes.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] IMEM_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] IMEM_BYTES_DEF = 32'h0000_1000;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  typedef enum logic {
    RUN,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            exc;
  } fetch_bundle_t;

  localparam int FB_W = $bits(fetch_bundle_t);

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer for the fetch bundle.
// Flush wins over push; push and pop together replace the entry.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic            CLK,
  input  logic            Reset,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_flush,
  input  logic [FB_W-1:0] i_data,
  output logic            o_full,
  output logic [FB_W-1:0] o_data
);

  logic            r_full;
  logic [FB_W-1:0] r_data;

  always_ff @(posedge CLK) begin
    if (Reset || i_flush) begin
      r_full <= 1'b0;
    end else if (i_push) begin
      r_full <= 1'b1;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_data <= '0;
    end else if (i_push) begin
      r_data <= i_data;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, imem handshake, skid buffer and redirect drain.
// Define FETCH_EXC_EN for address-error exceptions (exc_o/exc_code_o).
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
`ifdef FETCH_EXC_EN
  ,
  parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEF,
  parameter logic [31:0] IMEM_BYTES = IMEM_BYTES_DEF
`endif
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] IMcode_o,
  output logic [31:0] PC_o,
  output logic [31:0] PC4_o,
  output logic [31:0] PC8_o,
  output logic        valid_o
`ifdef FETCH_EXC_EN
  ,
  output logic        exc_o,
  output logic [4:0]  exc_code_o
`endif
);

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   r_req_addr;
  logic [31:0]   r_pending_pc;
  logic [31:0]   r_pc4;
  logic [31:0]   r_pc8;
  logic          r_busy;
  logic          r_valid;
  logic          r_halt;
  fetch_bundle_t r_out;

  fetch_bundle_t w_new;
  fetch_bundle_t w_ld;
  fetch_bundle_t w_skid_q;
  logic          w_skid_full;
  logic [31:0]   w_target;
  logic          w_bad;
  logic          w_req;
  logic          w_outst;
  logic          w_fill;
  logic          w_exc_fire;
  logic          w_new_vld;
  logic          w_consume;
  logic          w_slot;
  logic          w_push;
  logic          w_pop;
  logic          w_unused;

`ifdef FETCH_EXC_EN
  assign w_target = redirect_pc_i;
  assign w_bad    = (r_pc[1:0] != 2'b00) |
                    ((r_pc - IMEM_BASE) >= IMEM_BYTES);
`else
  assign w_target = word_align(redirect_pc_i);
  assign w_bad    = 1'b0;
`endif

  assign w_req = ~Reset &
                 ((r_state == DRAIN) | r_busy |
                  (~w_skid_full & ~r_halt & ~w_bad));

  assign imem_req_o  = w_req;
  assign imem_addr_o = (r_busy | (r_state == DRAIN))
                       ? r_req_addr : r_pc;

  assign w_outst    = w_req & ~imem_ready_i;
  assign w_fill     = (r_state == RUN) & w_req &
                      imem_ready_i & ~redirect_i;
  assign w_exc_fire = (r_state == RUN) & ~r_busy &
                      ~w_skid_full & ~r_halt & w_bad &
                      ~redirect_i & ~Reset;
  assign w_new_vld  = w_fill | w_exc_fire;
  assign w_consume  = r_valid & ~stall_i;
  assign w_slot     = ~r_valid | w_consume;

  // Older skid content always leaves first; the new word queues behind it.
  assign w_push = ~redirect_i & w_new_vld &
                  (~w_slot | w_skid_full);
  assign w_pop  = ~redirect_i & w_skid_full & w_consume;

  always_comb begin
    w_new = '0;
    if (w_exc_fire) begin
      w_new.instr = NOP;
      w_new.pc    = r_pc;
      w_new.exc   = 1'b1;
    end else begin
      w_new.instr = imem_rdata_i;
      w_new.pc    = imem_addr_o;
    end
  end

  assign w_ld = w_skid_full ? w_skid_q : w_new;

  fetch_skid_buf u_skid (
    .CLK     (CLK),
    .Reset   (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .i_data  (w_new),
    .o_full  (w_skid_full),
    .o_data  (w_skid_q)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN: begin
        if (redirect_i && w_outst) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_ready_i) begin
          w_state_nxt = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_pending_pc <= RESET_PC;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_halt       <= 1'b0;
      r_out        <= '0;
      r_pc4        <= '0;
      r_pc8        <= '0;
    end else begin
      r_req_addr <= imem_addr_o;
      r_busy     <= w_outst;
      if (redirect_i) begin
        r_valid      <= 1'b0;
        r_halt       <= 1'b0;
        r_pc         <= w_target;
        r_pending_pc <= w_target;
      end else begin
        if ((r_state == DRAIN) && imem_ready_i) begin
          r_pc <= r_pending_pc;
        end else if (w_fill) begin
          r_pc <= r_pc + 32'd4;
        end
        if (w_exc_fire) begin
          r_halt <= 1'b1;
        end
        if (w_slot) begin
          if (w_skid_full || w_new_vld) begin
            r_out   <= w_ld;
            r_pc4   <= w_ld.pc + 32'd4;
            r_pc8   <= w_ld.pc + 32'd8;
            r_valid <= 1'b1;
          end else begin
            r_valid <= 1'b0;
          end
        end
      end
    end
  end

  assign IMcode_o = r_out.instr;
  assign PC_o     = r_out.pc;
  assign PC4_o    = r_pc4;
  assign PC8_o    = r_pc8;
  assign valid_o  = r_valid;

`ifdef FETCH_EXC_EN
  assign exc_o      = r_out.exc;
  assign exc_code_o = r_out.exc ? EXC_ADEL : 5'd0;
`endif

  assign w_unused = ^{redirect_pc_i[1:0], r_out.exc};

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed cases plus random run.
// Exception cases are built only when FETCH_EXC_EN is defined.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_ready_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] IMcode_o;
  logic [31:0] PC_o;
  logic [31:0] PC4_o;
  logic [31:0] PC8_o;
  logic        valid_o;
`ifdef FETCH_EXC_EN
  logic        exc_o;
  logic [4:0]  exc_code_o;
`endif

  always #5 CLK = ~CLK;

  fetch_stage dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rdata_i  (imem_rdata_i),
    .IMcode_o      (IMcode_o),
    .PC_o          (PC_o),
    .PC4_o         (PC4_o),
    .PC8_o         (PC8_o),
    .valid_o       (valid_o)
`ifdef FETCH_EXC_EN
    ,
    .exc_o         (exc_o),
    .exc_code_o    (exc_code_o)
`endif
  );

  int          n_chk = 0;
  int          n_err = 0;
  bit          waiting = 0;
  int          cnt = 0;
  int          mem_delay = 0;
  bit          mem_rand = 0;
  bit          rnd_on = 0;
  logic [31:0] exp_pc = '0;
  int          idle = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Instruction memory: answers each request after a chosen delay.
  task automatic mem_drive();
    if (Reset) begin
      waiting = 0;
      imem_ready_i = 1'b0;
    end else if (imem_req_o) begin
      if (!waiting) begin
        waiting = 1;
        cnt = mem_rand ? int'($urandom_range(0, 3)) : mem_delay;
      end
      if (cnt == 0) begin
        imem_ready_i = 1'b1;
        imem_rdata_i = memfn(imem_addr_o);
        waiting = 0;
      end else begin
        imem_ready_i = 1'b0;
        imem_rdata_i = 32'hDEAD_BEEF;
        cnt--;
      end
    end else begin
      imem_ready_i = 1'b0;
    end
  endtask

  task automatic step();
    logic        p_req;
    logic        p_rdy;
    logic        p_rst;
    logic [31:0] p_addr;
    #1;
    mem_drive();
    #1;
    p_req  = imem_req_o;
    p_rdy  = imem_ready_i;
    p_rst  = Reset;
    p_addr = imem_addr_o;
    if (rnd_on && !Reset) begin
      if (redirect_i) begin
        exp_pc = redirect_pc_i;
        idle = 0;
      end else if (valid_o && !stall_i) begin
        chk("rnd_pc", PC_o, exp_pc);
        chk("rnd_code", IMcode_o, memfn(exp_pc));
        chk("rnd_pc4", PC4_o, exp_pc + 32'd4);
        chk("rnd_pc8", PC8_o, exp_pc + 32'd8);
        exp_pc = exp_pc + 32'd4;
        idle = 0;
      end else begin
        idle++;
        if (idle > 100) begin
          chk("rnd_live", 32'(idle), 32'd100);
          idle = 0;
        end
      end
    end
    @(posedge CLK);
    #1;
    if (p_req && !p_rdy && !p_rst) begin
      chk("req_hold", 32'(imem_req_o), 32'd1);
      chk("addr_hold", imem_addr_o, p_addr);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    step();
    chk("rst_req", 32'(imem_req_o), 32'd0);
    step();
    Reset = 1'b0;
    #1;
  endtask

  initial begin
    // 1: streaming fetch
    mem_rand = 0;
    mem_delay = 0;
    do_reset();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_pc", PC_o, 32'd0);
    chk("rst_pc4", PC4_o, 32'd0);
    chk("rst_code", IMcode_o, 32'd0);
    chk("t1_req0", 32'(imem_req_o), 32'd1);
    chk("t1_addr0", imem_addr_o, 32'h3000);
    step();
    chk("t1_valid", 32'(valid_o), 32'd1);
    chk("t1_pc_a", PC_o, 32'h3000);
    chk("t1_addr1", imem_addr_o, 32'h3004);
    step();
    chk("t1_pc_b", PC_o, 32'h3004);
    chk("t1_pc8_b", PC8_o, 32'h300C);
    chk("t1_addr2", imem_addr_o, 32'h3008);
    step();
    chk("t1_pc_c", PC_o, 32'h3008);
    chk("t1_pc8_c", PC8_o, 32'h3010);

    // 2: slow first fetch
    mem_delay = 3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("t2_req", 32'(imem_req_o), 32'd1);
      chk("t2_addr", imem_addr_o, 32'h3000);
      chk("t2_valid0", 32'(valid_o), 32'd0);
      step();
      mem_delay = 0;
    end
    chk("t2_valid1", 32'(valid_o), 32'd1);
    chk("t2_pc", PC_o, 32'h3000);

    // 3: stall with skid capture
    do_reset();
    step();
    step();
    chk("t3_pc0", PC_o, 32'h3004);
    stall_i = 1'b1;
    step();
    chk("t3_hold1", PC_o, 32'h3004);
    chk("t3_noreq1", 32'(imem_req_o), 32'd0);
    step();
    chk("t3_hold2", PC_o, 32'h3004);
    chk("t3_noreq2", 32'(imem_req_o), 32'd0);
    step();
    stall_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_seq_v", 32'(valid_o), 32'd1);
      chk("t3_seq_pc", PC_o, 32'h3004 + 32'(4 * i));
      step();
    end

    // 4: redirect while a fetch waits
    do_reset();
    for (int i = 0; i < 20 && imem_addr_o !== 32'h3010; i++) step();
    chk("t4_reach", imem_addr_o, 32'h3010);
    mem_delay = 2;
    step();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h3100;
    step();
    redirect_i = 1'b0;
    mem_delay = 0;
    chk("t4_drain_req", 32'(imem_req_o), 32'd1);
    chk("t4_drain_addr", imem_addr_o, 32'h3010);
    chk("t4_drain_v", 32'(valid_o), 32'd0);
    step();
    chk("t4_new_addr", imem_addr_o, 32'h3100);
    chk("t4_new_v", 32'(valid_o), 32'd0);
    step();
    chk("t4_out_v", 32'(valid_o), 32'd1);
    chk("t4_out_pc", PC_o, 32'h3100);
    chk("t4_out_code", IMcode_o, memfn(32'h3100));

    // 5: redirect on ready (with stall), then redirects in DRAIN
    do_reset();
    step();
    step();
    stall_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h3200;
    step();
    stall_i = 1'b0;
    redirect_i = 1'b0;
    chk("t5_flush_v", 32'(valid_o), 32'd0);
    chk("t5_addr", imem_addr_o, 32'h3200);
    mem_delay = 3;
    step();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h3280;
    step();
    redirect_pc_i = 32'h3300;
    chk("t5_drain_addr", imem_addr_o, 32'h3200);
    chk("t5_drain_v", 32'(valid_o), 32'd0);
    step();
    redirect_i = 1'b0;
    chk("t5_drain_addr2", imem_addr_o, 32'h3200);
    mem_delay = 0;
    step();
    chk("t5_last_addr", imem_addr_o, 32'h3300);
    chk("t5_last_v", 32'(valid_o), 32'd0);
    step();
    chk("t5_out_v", 32'(valid_o), 32'd1);
    chk("t5_out_pc", PC_o, 32'h3300);

`ifdef FETCH_EXC_EN
    // 6: unaligned redirect raises AdEL and halts fetch
    do_reset();
    step();
    step();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h3102;
    step();
    redirect_i = 1'b0;
    chk("t6_noreq0", 32'(imem_req_o), 32'd0);
    step();
    chk("t6_v", 32'(valid_o), 32'd1);
    chk("t6_code", IMcode_o, 32'd0);
    chk("t6_exc", 32'(exc_o), 32'd1);
    chk("t6_cause", 32'(exc_code_o), 32'd4);
    chk("t6_pc", PC_o, 32'h3102);
    chk("t6_noreq1", 32'(imem_req_o), 32'd0);
    step();
    step();
    chk("t6_halt_v", 32'(valid_o), 32'd0);
    chk("t6_halt_req", 32'(imem_req_o), 32'd0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h3000;
    step();
    redirect_i = 1'b0;
    chk("t6_resume_req", 32'(imem_req_o), 32'd1);
    chk("t6_resume_addr", imem_addr_o, 32'h3000);
    step();
    chk("t6_resume_pc", PC_o, 32'h3000);
    chk("t6_resume_exc", 32'(exc_o), 32'd0);
`else
    // 6: unaligned redirect target is masked
    do_reset();
    step();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h3106;
    step();
    redirect_i = 1'b0;
    chk("t6_mask_addr", imem_addr_o, 32'h3104);
    step();
    chk("t6_mask_pc", PC_o, 32'h3104);
`endif

    // 7: reset while a request waits
    mem_delay = 5;
    do_reset();
    step();
    step();
    Reset = 1'b1;
    step();
    chk("t7_req", 32'(imem_req_o), 32'd0);
    chk("t7_v", 32'(valid_o), 32'd0);
    chk("t7_pc", PC_o, 32'd0);
    chk("t7_pc8", PC8_o, 32'd0);
    chk("t7_code", IMcode_o, 32'd0);
    Reset = 1'b0;
    mem_delay = 0;
    #1;
    chk("t7_addr", imem_addr_o, 32'h3000);
    step();
    chk("t7_out_pc", PC_o, 32'h3000);

    // 8: random stall/redirect/latency against the stream model
    do_reset();
    mem_rand = 1;
    exp_pc = 32'h3000;
    rnd_on = 1;
    for (int i = 0; i < 3000; i++) begin
      stall_i = ($urandom_range(0, 9) < 3);
      redirect_i = ($urandom_range(0, 19) == 0);
      redirect_pc_i = 32'h3000 + (32'($urandom_range(0, 511)) << 2);
      step();
    end
    rnd_on = 0;
    stall_i = 1'b0;
    redirect_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
